// File: rtl/out_word_fifo_if.sv
// Handshake bundle between the cipher result producer, out_word_fifo and the host reader.
// slave faces the FIFO; master faces the producer/consumer pair.
interface out_word_fifo_if #(
  parameter int OUT_W    = 32,
  parameter int IN_WORDS = 2,
  parameter int DEPTH    = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [IN_WORDS*OUT_W-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [OUT_W-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [CW-1:0]             count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );
endinterface

// File: rtl/out_word_fifo.sv
// Block-in / word-out circular FIFO for cipher results with ready/valid on both sides.
// Optional registered read stage: define OUT_WORD_FIFO_REG_OUT_EN (default is first-word-fall-through).
module out_word_fifo #(
  parameter int OUT_W    = 32,
  parameter int IN_WORDS = 2,
  parameter int DEPTH    = 8
) (
  input logic            clk,
  input logic            n_rst,
  input logic            clear,
  out_word_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;

  // No credit is taken for a same-cycle pop; space is judged from the registered count.
  assign bus.in_ready = (CW'(DEPTH) - count_q) >= CW'(IN_WORDS);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;
  assign bus.count    = count_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
    end else if (push) begin
      for (int k = 0; k < IN_WORDS; k++)
        mem[wr_ptr + AW'(k)] <= bus.in_data[k*OUT_W +: OUT_W];
      wr_ptr <= wr_ptr + AW'(IN_WORDS);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      count_q <= '0;
    else if (clear)
      count_q <= '0;
    else
      count_q <= count_q + (push ? CW'(IN_WORDS) : CW'(0)) - (pop ? CW'(1) : CW'(0));
  end

`ifdef OUT_WORD_FIFO_REG_OUT_EN
  logic [OUT_W-1:0] oreg;
  logic             oreg_valid;
  logic [CW-1:0]    held;
  logic             load;

  // count covers the output register too, so storage holds count minus that word.
  assign held = count_q - CW'(oreg_valid);
  assign load = (!oreg_valid || pop) && (held != '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      oreg       <= '0;
      oreg_valid <= 1'b0;
      rd_ptr     <= '0;
    end else if (clear) begin
      oreg       <= '0;
      oreg_valid <= 1'b0;
      rd_ptr     <= '0;
    end else if (load) begin
      oreg       <= mem[rd_ptr];
      oreg_valid <= 1'b1;
      rd_ptr     <= rd_ptr + AW'(1);
    end else if (pop) begin
      oreg_valid <= 1'b0;
    end
  end

  assign bus.out_data  = oreg;
  assign bus.out_valid = oreg_valid;
`else
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      rd_ptr <= '0;
    else if (clear)
      rd_ptr <= '0;
    else if (pop)
      rd_ptr <= rd_ptr + AW'(1);
  end

  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_valid = (count_q != '0);
`endif
endmodule

// File: tb/tb_out_word_fifo.sv
// Directed self-checking bench for out_word_fifo (default parameters).
// Also builds with OUT_WORD_FIFO_REG_OUT_EN to cover the 2-edge registered read path.
module tb_out_word_fifo;
  logic clk;
  logic n_rst;
  logic clear;

  out_word_fifo_if #(.OUT_W(32), .IN_WORDS(2), .DEPTH(8)) bus ();

  out_word_fifo #(.OUT_W(32), .IN_WORDS(2), .DEPTH(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lets the registered output stage catch up; no-op for fall-through.
  task automatic settle();
`ifdef OUT_WORD_FIFO_REG_OUT_EN
    tick();
`endif
  endtask

  task automatic push_block(input logic [63:0] data);
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    @(negedge clk);
    acc = bus.in_ready;
    tick();
    bus.in_valid = 1'b0;
    if (acc) begin
      q.push_back(data[31:0]);
      q.push_back(data[63:32]);
    end
  endtask

  task automatic pop_word(input string tag);
    logic [31:0] exp;
    exp = (q.size() != 0) ? q[0] : 32'hDEAD_BEEF;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_data"}, 64'(bus.out_data), 64'(exp));
    tick();
    bus.out_ready = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  initial begin
    int sent, got, cyc, maxc;
    logic do_push, do_pop;
    logic [31:0] lo, exp_w;

    n_rst = 1'b0;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    tick();

    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);

    // single block, two pops
    push_block(64'h11111111_22222222);
    chk("one_count", 64'(bus.count), 64'd2);
`ifdef OUT_WORD_FIFO_REG_OUT_EN
    chk("one_lat_not_yet", 64'(bus.out_valid), 64'd0);
`endif
    settle();
    chk("one_out_valid", 64'(bus.out_valid), 64'd1);
    chk("one_out_data", 64'(bus.out_data), 64'h22222222);
    pop_word("one_pop0");
    chk("one_pop0_next", 64'(bus.out_data), 64'h11111111);
    chk("one_pop0_count", 64'(bus.count), 64'd1);
    pop_word("one_pop1");
    chk("one_pop1_count", 64'(bus.count), 64'd0);
    chk("one_pop1_valid", 64'(bus.out_valid), 64'd0);

    // fill to full, hold a fifth block against backpressure
    for (int b = 0; b < 4; b++)
      push_block({32'hA000_0000 + 32'(2*b+1), 32'hA000_0000 + 32'(2*b)});
    chk("full_count", 64'(bus.count), 64'd8);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 64'hB000_0009_B000_0008;
    tick();
    tick();
    chk("full_held_count", 64'(bus.count), 64'd8);
    pop_word("full_pop0");
    chk("full_pop0_count", 64'(bus.count), 64'd7);
    chk("full_pop0_in_ready", 64'(bus.in_ready), 64'd0);
    pop_word("full_pop1");
    chk("full_pop1_count", 64'(bus.count), 64'd6);
    chk("full_pop1_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    q.push_back(32'hB000_0008);
    q.push_back(32'hB000_0009);
    chk("full_accept_count", 64'(bus.count), 64'd8);
    for (int i = 0; i < 8; i++) pop_word("full_drain");
    chk("full_drain_count", 64'(bus.count), 64'd0);

    // push and pop on the same edge at count=3
    push_block(64'hC000_0001_C000_0000);
    push_block(64'hC000_0003_C000_0002);
    settle();
    pop_word("pp_pre");
    chk("pp_count3", 64'(bus.count), 64'd3);
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hC000_0005_C000_0004;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("pp_both_data", 64'(bus.out_data), 64'hC000_0001);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    void'(q.pop_front());
    q.push_back(32'hC000_0004);
    q.push_back(32'hC000_0005);
    chk("pp_count4", 64'(bus.count), 64'd4);
    for (int i = 0; i < 4; i++) pop_word("pp_drain");
    chk("pp_drain_count", 64'(bus.count), 64'd0);

    // streaming with random consumer backpressure across several wraps
    sent = 0; got = 0; cyc = 0; maxc = 0;
    while (got < 40 && cyc < 2000) begin
      lo = 32'h100 + 32'(2*sent);
      bus.in_valid  = (sent < 20);
      bus.in_data   = {lo + 32'd1, lo};
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      do_push = bus.in_valid && bus.in_ready;
      do_pop  = bus.out_valid && bus.out_ready;
      if (do_pop) begin
        exp_w = (q.size() != 0) ? q.pop_front() : 32'hDEAD_BEEF;
        chk("stream_data", 64'(bus.out_data), 64'(exp_w));
      end
      tick();
      if (do_push) begin
        q.push_back(lo);
        q.push_back(lo + 32'd1);
        sent++;
      end
      if (do_pop) got++;
      if (int'(bus.count) > maxc) maxc = int'(bus.count);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("stream_words", 64'(got), 64'd40);
    chk("stream_blocks", 64'(sent), 64'd20);
    chk("stream_count_le8", 64'(maxc <= 8), 64'd1);
    chk("stream_end_count", 64'(bus.count), 64'd0);

    // clear dominates a same-cycle push and pop
    push_block(64'hD000_0001_D000_0000);
    push_block(64'hD000_0003_D000_0002);
    push_block(64'hD000_0005_D000_0004);
    settle();
    pop_word("clr_pre");
    chk("clr_count5", 64'(bus.count), 64'd5);
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hEEEE_EEEE_EEEE_EEEE;
    bus.out_ready = 1'b1;
    clear         = 1'b1;
    tick();
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    q.delete();
    chk("clr_count", 64'(bus.count), 64'd0);
    chk("clr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("clr_in_ready", 64'(bus.in_ready), 64'd1);
    push_block(64'hF000_0001_F000_0000);
    settle();
    pop_word("clr_after0");
    pop_word("clr_after1");
    chk("clr_after_count", 64'(bus.count), 64'd0);

    // reset mid-operation
    push_block(64'h1234_5678_9ABC_DEF0);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_count", 64'(bus.count), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_data", 64'(bus.out_data), 64'd0);
    q.delete();
    tick();
    n_rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/out_word_fifo.md
Name: out_word_fifo

Overview:
Parametrised output buffer for the cipher datapath. Accepts one cipher block of IN_WORDS words per push and emits one OUT_W-bit word per pop, using a circular buffer with ready/valid handshakes on both sides. It sits between the 3DES core result register and the bus/host read interface. It replaces the fixed 64-to-32, 8-entry shift buffer with a generic width/depth FIFO that has backpressure.

Parameters:
OUT_W, 32, width of one output word in bits
IN_WORDS, 2, output words per input block; input width is IN_WORDS*OUT_W
DEPTH, 8, storage depth in output words; power of 2; DEPTH >= 2*IN_WORDS

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous flush; empties buffer
in_data  input  IN_WORDS*OUT_W  cipher block; slice [OUT_W-1:0] is the first word out
in_valid  input  1  in_data valid
in_ready  output  1  buffer can accept a whole block this cycle
out_data  output  OUT_W  head word
out_valid  output  1  out_data valid
out_ready  input  1  consumer takes out_data this cycle
count  output  $clog2(DEPTH)+1  words currently held, including any word in the output register

Behaviour:
- Reset (n_rst low, async): storage, rd_ptr, wr_ptr, count and out_data go to 0; out_valid goes to 0. in_ready = 1 after reset.
- push = in_valid && in_ready. pop = out_valid && out_ready. Both are evaluated on the same rising edge.
- in_ready = (DEPTH - count) >= IN_WORDS, computed from the registered count. No look-ahead credit for a same-cycle pop.
- Push writes slice k of in_data to mem[(wr_ptr+k) mod DEPTH] for k = 0..IN_WORDS-1. wr_ptr then advances by IN_WORDS and wraps mod DEPTH.
- Pop advances rd_ptr by 1 and wraps mod DEPTH.
- count update:
  - push only: +IN_WORDS
  - pop only: -1
  - push and pop together: +IN_WORDS-1
  - neither: hold
- count never exceeds DEPTH and never underflows, by construction. A push while in_ready=0 is not a push: data is ignored and state is unchanged. in_valid may be held high while in_ready is low.
- Ordering: words leave in strict FIFO order, lowest slice of each block first. Order holds across pointer wrap-around.
- Default read path (first-word-fall-through):
  - out_data = mem[rd_ptr] combinationally; out_valid = (count != 0).
  - A word pushed at edge N is visible at out_data after edge N.
- clear (synchronous) dominates a same-cycle push or pop. Next cycle: count=0, pointers=0, out_valid=0. Storage contents need not be zeroed. A block presented in the clear cycle is dropped.
- Asserting reset mid-operation discards everything immediately, regardless of handshake state.

Optional Feature:
Macro: OUT_WORD_FIFO_REG_OUT_EN
- Defined: out_data and out_valid come from a registered output stage.
  - The stage loads from mem[rd_ptr] when it is empty or popped, and storage holds a word.
  - Latency from push to out_valid is 2 edges.
  - Back-to-back pops sustain 1 word/cycle.
  - count includes the word in the output register.
  - clear and reset also empty the register (out_valid=0, out_data=0).
- Undefined: combinational first-word-fall-through read path as above, 1-edge latency.

Test Plan:
- Reset, then idle -> count=0, out_valid=0, in_ready=1, out_data=0.
- Push in_data=0x11111111_22222222 (defaults) -> next cycle count=2, out_valid=1, out_data=0x22222222. One pop -> out_data=0x11111111, count=1. Second pop -> count=0, out_valid=0.
- Push 4 blocks with no pops -> count=8, in_ready=0; a held 5th block is not written and count stays 8. One pop -> count=7, in_ready still 0. Second pop -> count=6, in_ready=1, and the 5th block is accepted on that cycle's edge.
- At count=3, push and pop on the same edge -> count=4; the words read back are the next 4 pushed words in order, with no duplication or loss.
- Stream 20 blocks with an incrementing pattern and out_ready toggling pseudo-randomly -> 40 words out in exact order across multiple wraps, count <= 8 throughout.
- At count=5, assert clear together with push and pop -> next cycle count=0, out_valid=0, in_ready=1; the dropped block never appears at the output. Repeat both tests with OUT_WORD_FIFO_REG_OUT_EN defined to check 2-edge latency.
